// File: rtl/mmss_countdown.sv
// mm:ss BCD countdown timer for the cook-time path.
// Run/pause/done control, load saturation and a one-cycle done pulse.
module mmss_countdown #(
    parameter int MIN_DIGITS   = 2,
    parameter int SEC_TENS_MOD = 6
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          loadn,
    input  logic [4*(MIN_DIGITS+2)-1:0]   data,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          tick,
    output logic [4*(MIN_DIGITS+2)-1:0]   out,
    output logic                          zero,
    output logic                          running,
    output logic                          done
);

    localparam int D = MIN_DIGITS + 2;
    localparam int W = 4 * D;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_out;
    logic [W-1:0]   w_out_nxt;
    logic [W-1:0]   w_sat;
    logic [W-1:0]   w_dec;
    logic           r_zero;
    logic           r_done;
    logic           w_done_nxt;

    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 1) ? 4'(SEC_TENS_MOD - 1) : 4'd9;
    endfunction

    always_comb begin : sat_blk
        w_sat = data;
        for (int i = 0; i < D; i++) begin
            if (data[4*i +: 4] > digit_max(i))
                w_sat[4*i +: 4] = digit_max(i);
        end
    end

    // Ripple borrow: a zero digit wraps to its max and passes the borrow up.
    always_comb begin : dec_blk
        logic b;
        b     = 1'b1;
        w_dec = r_out;
        for (int i = 0; i < D; i++) begin
            if (b) begin
                if (r_out[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = digit_max(i);
                end else begin
                    w_dec[4*i +: 4] = r_out[4*i +: 4] - 4'd1;
                    b               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_zero  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_zero  <= (w_out_nxt == '0);
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_done_nxt  = 1'b0;
        if (!loadn) begin
            w_state_nxt = S_IDLE;
            w_out_nxt   = w_sat;
        end else if (stop) begin
            unique case (r_state)
                S_RUN:    w_state_nxt = S_PAUSED;
                S_PAUSED: begin
                    w_state_nxt = S_IDLE;
                    w_out_nxt   = '0;
                end
                S_DONE:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end else if (start) begin
            if ((r_state == S_IDLE && !r_zero) || r_state == S_PAUSED)
                w_state_nxt = S_RUN;
        end else if (tick && r_state == S_RUN) begin
            w_out_nxt = w_dec;
            if (w_dec == '0) begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
            end
        end
    end

    always_comb begin
        running = (r_state == S_RUN);
        out     = r_out;
        zero    = r_zero;
        done    = r_done;
    end

endmodule

// File: tb/tb_mmss_countdown.sv
// Scenario bench for mmss_countdown: per-step expectations go through a
// scoreboard queue and are compared after each clock edge.
module tb_mmss_countdown;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        loadn = 1'b1;
    logic [15:0] data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] out;
    logic        zero;
    logic        running;
    logic        done;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        c;
        logic        ln;
        logic [15:0] d;
        logic        st;
        logic        sp;
        logic        tk;
        logic [15:0] o;
        logic        z;
        logic        r;
        logic        dn;
    } step_t;

    typedef struct packed {
        logic [15:0] o;
        logic        z;
        logic        r;
        logic        dn;
    } exp_t;

    exp_t sb[$];

    mmss_countdown #(.MIN_DIGITS(2), .SEC_TENS_MOD(6)) dut (
        .clk(clk), .clr(clr), .loadn(loadn), .data(data),
        .start(start), .stop(stop), .tick(tick),
        .out(out), .zero(zero), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(
        input logic c, input logic ln, input logic [15:0] d,
        input logic st, input logic sp, input logic tk,
        input logic [15:0] o, input logic z, input logic r, input logic dn);
        step_t s;
        s = '{c, ln, d, st, sp, tk, o, z, r, dn};
        return s;
    endfunction

    task automatic apply(input step_t s);
        @(negedge clk);
        clr   = s.c;
        loadn = s.ln;
        data  = s.d;
        start = s.st;
        stop  = s.sp;
        tick  = s.tk;
        sb.push_back('{s.o, s.z, s.r, s.dn});
        @(posedge clk);
        #1;
        clr   = 1'b0;
        loadn = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic test_reset();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(1, 1, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 1, 16'h0000, 1, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            n_vec++;
            if ({out, zero, running, done} !== e) begin
                n_fail++;
                $display("FAIL reset/startzero step %0d: got %h z%b r%b d%b want %h z%b r%b d%b",
                         i, out, zero, running, done, e.o, e.z, e.r, e.dn);
            end
        end
    endtask

    task automatic test_rollover();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(1, 1, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0));
        q.push_back(mk(0, 0, 16'h0105, 0, 0, 0, 16'h0105, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 1, 16'h0105, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0104, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0103, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0102, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 0, 16'h0102, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0101, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0100, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0059, 0, 1, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            n_vec++;
            if ({out, zero, running, done} !== e) begin
                n_fail++;
                $display("FAIL rollover step %0d: got %h z%b r%b d%b want %h z%b r%b d%b",
                         i, out, zero, running, done, e.o, e.z, e.r, e.dn);
            end
        end
    endtask

    task automatic test_done_pulse();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(0, 0, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 16'h0002, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0001, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 1));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 1, 16'h0000, 1, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 1, 16'h0000, 1, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            n_vec++;
            if ({out, zero, running, done} !== e) begin
                n_fail++;
                $display("FAIL done_pulse step %0d: got %h z%b r%b d%b want %h z%b r%b d%b",
                         i, out, zero, running, done, e.o, e.z, e.r, e.dn);
            end
        end
    endtask

    task automatic test_pause_cancel();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(0, 0, 16'h0130, 0, 0, 0, 16'h0130, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 16'h0130, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0129, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0128, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 1, 1, 16'h0128, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0128, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0128, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0128, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 1, 16'h0128, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0127, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 1, 0, 16'h0127, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            n_vec++;
            if ({out, zero, running, done} !== e) begin
                n_fail++;
                $display("FAIL pause_cancel step %0d: got %h z%b r%b d%b want %h z%b r%b d%b",
                         i, out, zero, running, done, e.o, e.z, e.r, e.dn);
            end
        end
    endtask

    task automatic test_saturation();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(0, 0, 16'hFA7F, 0, 0, 0, 16'h9959, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 16'h9959, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h9958, 0, 1, 0));
        q.push_back(mk(0, 0, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 16'h1000, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0959, 0, 1, 0));
        q.push_back(mk(0, 0, 16'h0C9B, 0, 0, 0, 16'h0959, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            n_vec++;
            if ({out, zero, running, done} !== e) begin
                n_fail++;
                $display("FAIL saturation step %0d: got %h z%b r%b d%b want %h z%b r%b d%b",
                         i, out, zero, running, done, e.o, e.z, e.r, e.dn);
            end
        end
    endtask

    task automatic test_priority();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(0, 0, 16'h0200, 0, 0, 0, 16'h0200, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 16'h0200, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0159, 0, 1, 0));
        q.push_back(mk(0, 0, 16'h0045, 1, 1, 1, 16'h0045, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 1, 16'h0045, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 1, 1, 16'h0045, 0, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 16'h0045, 0, 1, 0));
        q.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 16'h0044, 0, 1, 0));
        q.push_back(mk(1, 0, 16'h0077, 1, 0, 1, 16'h0000, 1, 0, 0));
        q.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0));
        q.push_back(mk(0, 1, 16'h0000, 1, 0, 1, 16'h0000, 1, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            n_vec++;
            if ({out, zero, running, done} !== e) begin
                n_fail++;
                $display("FAIL priority step %0d: got %h z%b r%b d%b want %h z%b r%b d%b",
                         i, out, zero, running, done, e.o, e.z, e.r, e.dn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_done_pulse();
        test_pause_cancel();
        test_saturation();
        test_priority();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mmss_countdown.md
Name: mmss_countdown

Overview:
- Parametrised multi-digit BCD countdown timer for the microwave cook-time path: minutes:seconds display digits with cascaded borrow.
- Seconds-ones digit counts mod 10, seconds-tens mod 6, minute digits mod 10.
- Adds a run/pause/done state machine, load saturation and a one-cycle done pulse.
- Sits between the keypad/load logic and the display driver; decrements on a 1 Hz tick enable.

Parameters:
- MIN_DIGITS, 2, number of BCD minute digits (1..4); total digits D = MIN_DIGITS+2, bus width W = 4*D.
- SEC_TENS_MOD, 6, modulus of the seconds-tens digit (2..10).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- clr  in  1  synchronous active-high reset.
- loadn  in  1  active-low synchronous load of data.
- data  in  W  BCD preset, digit 0 (seconds ones) in [3:0], most-significant minute digit on top.
- start  in  1  start/resume request, level-sampled each cycle.
- stop  in  1  pause/cancel request, level-sampled each cycle.
- tick  in  1  one-cycle count enable (1 s period).
- out  out  W  current BCD count, registered.
- zero  out  1  registered, 1 when out == 0.
- running  out  1  1 while in RUN.
- done  out  1  one-cycle pulse when the count reaches 0 under RUN.

Behaviour:
- One clock; reset is synchronous and active-high: clk, clr.
- Reset values (clr high at an edge, from any state, including mid-run): out=0, zero=1, running=0, done=0, state=IDLE.
- Input priority per cycle: clr > loadn > stop > start > tick.
- Load (loadn=0, any state): state->IDLE, done=0.
  - Each digit is loaded from data; a digit >= its modulus saturates to modulus-1. Example: seconds-tens 7 with mod 6 loads 5; any minute digit A..F loads 9.
  - zero is updated from the saturated value.
- States:
  - IDLE: start & !zero -> RUN. start & zero -> stay IDLE. tick is ignored.
  - RUN:
    - stop -> PAUSED; a tick in the same cycle is ignored.
    - Otherwise, on tick, decrement by one second.
    - If the decremented value is 0: state->DONE, done=1 for exactly that cycle (aligned with out becoming 0), zero=1.
  - PAUSED: start -> RUN. stop -> IDLE and out cleared to 0, zero=1 (cancel). tick is ignored.
  - DONE: stop -> IDLE. start and tick are ignored. out stays 0.
- running = (state==RUN), registered with the state.
- A start cycle does not decrement, even if tick is also high. The first decrement is on the next tick.
- Decrement rule: digit 0 borrows from digit 1, digit 1 from digit 2, and so on.
  - A digit at 0 that receives a borrow wraps to modulus-1 and propagates the borrow.
  - Example: 10:00 -> 09:59.
  - The count is never decremented from 0 (RUN cannot hold 0; that state is DONE).
- done is a single-cycle pulse and is deasserted in all other cycles.
- zero always equals (out==0) from the cycle after any update.

Test Plan:
- Rollover: clr; loadn=0 data=0x0105; start; 6 ticks -> out sequence 0104,0103,0102,0101,0100,0059; running=1 throughout; done=0.
- Done pulse: load 0x0002; start; tick, tick -> out 0001 then 0000; done=1 for one cycle on the second tick edge; zero=1, running=0; further ticks and start leave out=0000 and done=0.
- Pause/cancel: load 0x0130; start; 2 ticks -> 0128; stop -> running=0; 3 ticks -> out stays 0128; start then tick -> 0127; stop, stop -> out=0000, zero=1, state IDLE.
- Saturation and width (MIN_DIGITS=2): load 0xFA7F -> out 9959; start; tick -> 9958. Load 0x1000; start; tick -> 0959.
- Priority and reset: in RUN, loadn=0 with stop=1, start=1, tick=1 in the same cycle -> data loaded, state IDLE, no decrement. clr=1 mid-run with tick=1 -> out=0, zero=1, running=0, done=0 at that edge.
- Start at zero: after clr, start with tick -> stays IDLE, running=0, done never asserts.
